// File: rtl/led_pkg.sv
// led_pkg: shared constants, FSM encodings and helpers
// for the LED frame scheduler.
package led_pkg;

    localparam int LED_WIDTH          = 16;
    localparam int DEF_SHIFT_CYCLES   = 17;
    localparam int DEF_MIN_GAP        = 2;
    localparam int DEF_REFRESH_CYCLES = 0;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Bits needed to hold values 0..max_count (at least one).
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/led_frame_timer.sv
// led_frame_timer: loadable down-counter that holds at zero
// and flags done while the count is zero.
module led_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down to zero and stay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/led_update_ctrl.sv
// led_update_ctrl: coalescing frame scheduler in front of the
// serial LED shift-register driver.
module led_update_ctrl
    import led_pkg::*;
#(
    parameter int WIDTH          = LED_WIDTH,
    parameter int SHIFT_CYCLES   = DEF_SHIFT_CYCLES,
    parameter int MIN_GAP        = DEF_MIN_GAP,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int INVERT         = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             force_req,
    output logic [WIDTH-1:0] out_num,
    output logic             out_start,
    output logic             busy,
    output logic [7:0]       ovr_cnt
);

    localparam int MAXC = max3(SHIFT_CYCLES, MIN_GAP, REFRESH_CYCLES);
    localparam int CW   = cnt_width(MAXC);

    localparam logic [CW-1:0] SH_LOAD  = CW'(SHIFT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD =
        CW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [CW-1:0] REF_LOAD =
        CW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    localparam logic [WIDTH-1:0] RST_NUM =
        (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam bit HAS_GAP = (MIN_GAP > 0);
    localparam bit HAS_REF = (REFRESH_CYCLES > 0);

    if (SHIFT_CYCLES < 1) begin : g_bad_shift
        $error("led_update_ctrl: SHIFT_CYCLES must be >= 1");
    end
    if (MIN_GAP < 0) begin : g_bad_gap
        $error("led_update_ctrl: MIN_GAP must be >= 0");
    end
    if (REFRESH_CYCLES < 0) begin : g_bad_ref
        $error("led_update_ctrl: REFRESH_CYCLES must be >= 0");
    end

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_nxt;
    logic             pend_v;
    logic             pend_v_nxt;
    logic [WIDTH-1:0] last_sent;
    logic [WIDTH-1:0] latest;
    logic [WIDTH-1:0] frame_data;
    logic             acc;
    logic             wr_word;
    logic             wr_force;
    logic             ovr_inc;
    logic             go_load;

    logic             sh_load;
    logic [CW-1:0]    sh_val;
    logic             sh_en;
    logic             sh_done;
    logic             ref_load;
    logic             ref_en;
    logic             ref_done;
    logic             ref_expire;

    assign in_ready  = (state != ST_INIT);
    assign out_start = (state == ST_LOAD);
    assign busy      = (state == ST_LOAD) ||
                       (state == ST_SHIFT) ||
                       (state == ST_GAP);

    // Holding-register update: latest word wins, equal words drop.
    always_comb begin
        latest     = pend_v ? pend : last_sent;
        acc        = in_valid && in_ready;
        wr_word    = acc && ((in_data != latest) || force_req);
        wr_force   = force_req && !pend_v && !wr_word;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        if (wr_word) begin
            pend_nxt   = in_data;
            pend_v_nxt = 1'b1;
        end else if (wr_force) begin
            pend_nxt   = last_sent;
            pend_v_nxt = 1'b1;
        end
        ovr_inc = wr_word && pend_v;
    end

    // Frame sequencing; a pending word starts as soon as the window ends.
    always_comb begin
        state_nxt  = state;
        go_load    = 1'b0;
        frame_data = pend_nxt;
        ref_expire = HAS_REF && ref_done;
        unique case (state)
            ST_INIT: begin
                state_nxt  = ST_LOAD;
                go_load    = 1'b1;
                frame_data = '0;
            end
            ST_IDLE: begin
                if (pend_v_nxt) begin
                    state_nxt = ST_LOAD;
                    go_load   = 1'b1;
                end else if (ref_expire) begin
                    state_nxt  = ST_LOAD;
                    go_load    = 1'b1;
                    frame_data = last_sent;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    if (HAS_GAP) begin
                        state_nxt = ST_GAP;
                    end else if (pend_v_nxt) begin
                        state_nxt = ST_LOAD;
                        go_load   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (sh_done) begin
                    if (pend_v_nxt) begin
                        state_nxt = ST_LOAD;
                        go_load   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Window timer runs the shift period, then reloads for the gap.
    always_comb begin
        sh_load = (state == ST_LOAD) ||
                  ((state == ST_SHIFT) && sh_done);
        sh_val  = (state == ST_LOAD) ? SH_LOAD : GAP_LOAD;
        sh_en   = (state == ST_SHIFT) || (state == ST_GAP);
    end

    // Refresh timer only counts while idle; rearmed everywhere else.
    always_comb begin
        ref_load = (state != ST_IDLE);
        ref_en   = (state == ST_IDLE);
    end

    led_frame_timer #(
        .W(CW)
    ) u_win_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .load_val (sh_val),
        .en       (sh_en),
        .done     (sh_done)
    );

    led_frame_timer #(
        .W(CW)
    ) u_ref_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ref_load),
        .load_val (REF_LOAD),
        .en       (ref_en),
        .done     (ref_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending word and its valid flag; a frame load consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            pend_v <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if ((state == ST_INIT) || go_load) begin
                pend_v <= 1'b0;
            end else begin
                pend_v <= pend_v_nxt;
            end
        end
    end

    // Output word and last-sent copy change only when entering LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sent <= '0;
            out_num   <= RST_NUM;
        end else if (go_load) begin
            last_sent <= frame_data;
            out_num   <= (INVERT != 0) ? ~frame_data : frame_data;
        end
    end

    // Saturating count of pending words lost to newer ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else if (ovr_inc && (ovr_cnt != 8'hFF)) begin
            ovr_cnt <= ovr_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_led_update_ctrl.sv
// tb_led_update_ctrl: randomized and directed checks of the
// LED frame scheduler against a start-time based reference.
module tb_led_update_ctrl;

    localparam int W    = 16;
    localparam int SH   = 17;
    localparam int GAP  = 2;
    localparam int REF  = 50;
    localparam int WIN  = 1 + SH + GAP;
    localparam int RPER = WIN + REF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         force_req = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_num;
    logic         out_start;
    logic         busy;
    logic [7:0]   ovr_cnt;

    always #5 clk = ~clk;

    led_update_ctrl #(
        .WIDTH          (W),
        .SHIFT_CYCLES   (SH),
        .MIN_GAP        (GAP),
        .REFRESH_CYCLES (REF),
        .INVERT         (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_req (force_req),
        .out_num   (out_num),
        .out_start (out_start),
        .busy      (busy),
        .ovr_cnt   (ovr_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: frames are described by the edge index of their start.
    bit           m_first;
    int           m_e;
    int           m_s;
    logic [W-1:0] m_pend;
    logic [W-1:0] m_last;
    logic [W-1:0] m_out;
    bit           m_pv;
    int           m_ovr;

    task automatic model_edge();
        logic [W-1:0] latest;
        if (m_first) begin
            m_first = 0;
            m_e = 0;
            m_s = 0;
            m_last = '0;
            m_pv = 0;
            m_pend = '0;
            m_out = ~m_last;
            m_ovr = 0;
            return;
        end
        m_e++;
        latest = m_pv ? m_pend : m_last;
        if (in_valid && ((in_data != latest) || force_req)) begin
            if (m_pv && m_ovr < 255) m_ovr++;
            m_pend = in_data;
            m_pv = 1;
        end else if (force_req && !m_pv) begin
            m_pend = m_last;
            m_pv = 1;
        end
        if ((m_e - m_s) >= WIN && m_pv) begin
            m_s = m_e;
            m_last = m_pend;
            m_pv = 0;
            m_out = ~m_pend;
        end else if ((m_e - m_s) >= RPER) begin
            m_s = m_e;
            m_out = ~m_last;
        end
    endtask

    int cyc = 0;
    int n_starts = 0;
    int prev_start = 0;
    int this_start = 0;

    task automatic check_outs();
        chk("out_start", 32'(out_start), 32'(m_s == m_e));
        chk("busy", 32'(busy), 32'((m_e - m_s) < WIN));
        chk("out_num", 32'(out_num), 32'(m_out));
        chk("ovr_cnt", 32'(ovr_cnt), 32'(m_ovr));
        chk("in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d,
                         input logic f);
        in_valid = v;
        in_data = d;
        force_req = f;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
        cyc++;
        if (out_start) begin
            n_starts++;
            prev_start = this_start;
            this_start = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic wait_start(input string tag, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle(1'b0, '0, 1'b0);
            got = out_start;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic reset_checks();
        chk("rst_start", 32'(out_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_ovr", 32'(ovr_cnt), 32'd0);
        chk("rst_num", 32'(out_num), 32'h0000FFFF);
    endtask

    logic [W-1:0] rd;
    int bc;
    int s0;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        m_first = 1;
        #1;
        chk("init_ready", 32'(in_ready), 32'd0);

        // blank frame, then busy length
        cycle(1'b0, '0, 1'b0);
        chk("blank_start", 32'(out_start), 32'd1);
        chk("blank_num", 32'(out_num), 32'h0000FFFF);
        bc = busy ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, '0, 1'b0);
            if (busy) bc++;
        end
        chk("busy_len", 32'(bc), 32'(WIN));

        // new word, then duplicate
        cycle(1'b1, 16'h0001, 1'b0);
        chk("w1_start", 32'(out_start), 32'd1);
        chk("w1_num", 32'(out_num), 32'h0000FFFE);
        idle(25);
        cycle(1'b1, 16'h0001, 1'b0);
        chk("dup_start", 32'(out_start), 32'd0);
        idle(25);

        // coalescing during shift
        cycle(1'b1, 16'h0040, 1'b0);
        idle(3);
        cycle(1'b1, 16'h0002, 1'b0);
        cycle(1'b1, 16'h0004, 1'b0);
        cycle(1'b1, 16'h0008, 1'b0);
        wait_start("burst_seen", 30);
        chk("burst_gap", 32'(this_start - prev_start), 32'(WIN));
        chk("burst_num", 32'(out_num), 32'h0000FFF7);
        chk("burst_ovr", 32'(ovr_cnt), 32'd2);
        idle(25);

        // force paths
        cycle(1'b1, 16'h0080, 1'b0);
        idle(25);
        cycle(1'b0, '0, 1'b1);
        chk("frc_start", 32'(out_start), 32'd1);
        chk("frc_num", 32'(out_num), 32'h0000FF7F);
        idle(25);
        s0 = n_starts;
        cycle(1'b1, 16'h0080, 1'b1);
        idle(25);
        chk("frc_once", 32'(n_starts - s0), 32'd1);

        // periodic refresh
        s0 = n_starts;
        cycle(1'b1, 16'h00F0, 1'b0);
        idle(160);
        chk("ref_cnt", 32'(n_starts - s0), 32'd3);
        chk("ref_gap", 32'(this_start - prev_start), 32'(RPER));
        chk("ref_num", 32'(out_num), 32'h0000FF0F);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0: rd = 16'h0001;
                1: rd = 16'h0080;
                2: rd = 16'h00F0;
                3: rd = m_pv ? m_pend : m_last;
                default: rd = W'($urandom);
            endcase
            cycle(($urandom_range(0, 9) < 3), rd,
                  ($urandom_range(0, 19) == 0));
        end
        idle(30);

        // reset in the middle of a shift window
        cycle(1'b1, 16'hBEEF, 1'b0);
        if (!out_start) wait_start("pre_rst_start", 40);
        cycle(1'b1, 16'h0101, 1'b0);
        cycle(1'b1, 16'h0202, 1'b0);
        idle(3);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_first = 1;
        cycle(1'b0, '0, 1'b0);
        chk("reblank_start", 32'(out_start), 32'd1);
        chk("reblank_num", 32'(out_num), 32'h0000FFFF);
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
